instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: reads one instruction word per PC value, holds it in the instruction
// register for the decoder and requests a PC increment once the word is captured.
module instruction_fetch #(
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 19,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] pc_address,
  input  logic                  fetch_start,
  input  logic                  flush,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic [DATA_WIDTH-1:0] ir_out,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic                  inc_pc_req,
  output logic                  fetch_busy,
  output logic                  fetch_error
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERROR
  } state_t;

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  wait_cnt, wait_cnt_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [DATA_WIDTH-1:0] ir_out_next;
  logic                  ir_valid_next;
  logic                  inc_pc_req_next;
  logic                  fetch_error_next;
  logic                  mem_rd_en_next;
  logic                  fetch_busy_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      mem_addr    <= '0;
      ir_out      <= '0;
      ir_valid    <= 1'b0;
      inc_pc_req  <= 1'b0;
      fetch_error <= 1'b0;
      mem_rd_en   <= 1'b0;
      fetch_busy  <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      mem_addr    <= mem_addr_next;
      ir_out      <= ir_out_next;
      ir_valid    <= ir_valid_next;
      inc_pc_req  <= inc_pc_req_next;
      fetch_error <= fetch_error_next;
      mem_rd_en   <= mem_rd_en_next;
      fetch_busy  <= fetch_busy_next;
    end
  end

  always_comb begin
    state_next       = state;
    wait_cnt_next    = wait_cnt;
    mem_addr_next    = mem_addr;
    ir_out_next      = ir_out;
    ir_valid_next    = ir_valid;
    inc_pc_req_next  = 1'b0;
    fetch_error_next = fetch_error;

    unique case (state)
      S_IDLE: begin
        if (fetch_start) begin
          mem_addr_next = pc_address;
          state_next    = S_REQ;
        end
      end
      S_REQ: begin
        wait_cnt_next = '0;
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        // A response in the final WAIT cycle still wins over the timeout.
        if (mem_rd_valid) begin
          ir_out_next     = mem_rd_data;
          ir_valid_next   = 1'b1;
          inc_pc_req_next = 1'b1;
          state_next      = S_HOLD;
        end else begin
          wait_cnt_next = wait_cnt + CNT_WIDTH'(1);
          if (wait_cnt == CNT_LAST) begin
            fetch_error_next = 1'b1;
            state_next       = S_ERROR;
          end
        end
      end
      S_HOLD: begin
        if (ir_ready) begin
          ir_valid_next = 1'b0;
          if (fetch_start) begin
            mem_addr_next = pc_address;
            state_next    = S_REQ;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_ERROR: begin
        ir_valid_next = 1'b0;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Flush discards any in-flight response but keeps the last instruction word.
    if (flush) begin
      state_next       = S_IDLE;
      mem_addr_next    = mem_addr;
      ir_out_next      = ir_out;
      ir_valid_next    = 1'b0;
      inc_pc_req_next  = 1'b0;
      fetch_error_next = 1'b0;
    end

    mem_rd_en_next  = (state_next == S_REQ);
    fetch_busy_next = (state_next == S_REQ) || (state_next == S_WAIT);
  end

  inc_pc_single_pulse: assert property (@(posedge CLK) disable iff (RESET) inc_pc_req |=> !inc_pc_req);
  rd_en_single_pulse:  assert property (@(posedge CLK) disable iff (RESET) mem_rd_en |=> !mem_rd_en);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomised
// back-to-back stream, with captured words tracked through an expected-value queue.
module tb_instruction_fetch;

  localparam int AW = 19;
  localparam int DW = 19;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [AW-1:0] pc_address;
  logic          fetch_start;
  logic          flush;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_valid;
  logic [DW-1:0] ir_out;
  logic          ir_valid;
  logic          ir_ready;
  logic          inc_pc_req;
  logic          fetch_busy;
  logic          fetch_error;

  int            checkCount = 0;
  int            failCount  = 0;
  logic [DW-1:0] expQ[$];

  instruction_fetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .pc_address(pc_address),
    .fetch_start(fetch_start),
    .flush(flush),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .ir_out(ir_out),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .inc_pc_req(inc_pc_req),
    .fetch_busy(fetch_busy),
    .fetch_error(fetch_error)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [AW-1:0] pc, input logic rdValid,
                               input logic [DW-1:0] rdData, input logic ready, input logic flushIn);
    fetch_start  = start;
    pc_address   = pc;
    mem_rd_valid = rdValid;
    mem_rd_data  = rdData;
    ir_ready     = ready;
    flush        = flushIn;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rdEn"},   32'(mem_rd_en),   0);
    checkOutput({tag, "_addr"},   32'(mem_addr),    0);
    checkOutput({tag, "_ir"},     32'(ir_out),      0);
    checkOutput({tag, "_irVal"},  32'(ir_valid),    0);
    checkOutput({tag, "_inc"},    32'(inc_pc_req),  0);
    checkOutput({tag, "_busy"},   32'(fetch_busy),  0);
    checkOutput({tag, "_err"},    32'(fetch_error), 0);
  endtask

  // Scoreboard consumer: every decoder handshake must deliver the oldest expected word.
  always @(negedge CLK) begin
    if (!RESET && ir_valid && ir_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("sbUnderflow", 1, 0);
      end else begin
        checkOutput("sbIrOut", 32'(ir_out), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    int            lat;

    RESET = 1'b1;
    applyStimulus(0, '0, 0, '0, 0, 0);
    tick();
    tick();
    checkAllZero("reset");
    RESET = 1'b0;

    $display("[TB] basic fetch and backpressure");
    applyStimulus(1, 19'h00012, 0, '0, 0, 0);
    tick();
    applyStimulus(0, 19'h00012, 0, '0, 0, 0);
    checkOutput("basicRdEn",  32'(mem_rd_en),  1);
    checkOutput("basicAddr",  32'(mem_addr),   32'h12);
    checkOutput("basicBusy",  32'(fetch_busy), 1);
    checkOutput("basicIrVal", 32'(ir_valid),   0);
    tick();
    checkOutput("waitRdEn", 32'(mem_rd_en),  0);
    checkOutput("waitBusy", 32'(fetch_busy), 1);
    applyStimulus(0, 19'h00012, 1, 19'h5A5A5, 0, 0);
    expQ.push_back(19'h5A5A5);
    tick();
    applyStimulus(1, 19'h00099, 0, '0, 0, 0);
    checkOutput("capIrVal", 32'(ir_valid),   1);
    checkOutput("capInc",   32'(inc_pc_req), 1);
    checkOutput("capIr",    32'(ir_out),     32'h5A5A5);
    checkOutput("capBusy",  32'(fetch_busy), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      applyStimulus(0, 19'h00099, 0, '0, 0, 0);
      checkOutput("bpIrVal", 32'(ir_valid),   1);
      checkOutput("bpIr",    32'(ir_out),     32'h5A5A5);
      checkOutput("bpInc",   32'(inc_pc_req), 0);
      checkOutput("bpRdEn",  32'(mem_rd_en),  0);
    end
    applyStimulus(1, 19'h00013, 0, '0, 1, 0);
    tick();
    applyStimulus(0, 19'h00013, 0, '0, 0, 0);
    checkOutput("b2bRdEn",  32'(mem_rd_en), 1);
    checkOutput("b2bAddr",  32'(mem_addr),  32'h13);
    checkOutput("b2bIrVal", 32'(ir_valid),  0);
    tick();
    applyStimulus(0, 19'h00013, 1, 19'h2B3C4, 0, 0);
    expQ.push_back(19'h2B3C4);
    tick();
    applyStimulus(0, 19'h00013, 0, '0, 1, 0);
    checkOutput("b2bCapIrVal", 32'(ir_valid),   1);
    checkOutput("b2bCapInc",   32'(inc_pc_req), 1);
    tick();
    applyStimulus(0, 19'h00013, 0, '0, 0, 0);
    checkOutput("relIrVal", 32'(ir_valid),   0);
    checkOutput("relBusy",  32'(fetch_busy), 0);

    $display("[TB] timeout");
    applyStimulus(1, 19'h00020, 0, '0, 0, 0);
    tick();
    applyStimulus(0, 19'h00020, 0, '0, 0, 0);
    tick();
    for (int i = 1; i < TO; i++) begin
      tick();
      checkOutput("toPendErr",  32'(fetch_error), 0);
      checkOutput("toPendBusy", 32'(fetch_busy),  1);
    end
    tick();
    checkOutput("toErr",   32'(fetch_error), 1);
    checkOutput("toIrVal", 32'(ir_valid),    0);
    checkOutput("toBusy",  32'(fetch_busy),  0);
    checkOutput("toInc",   32'(inc_pc_req),  0);
    applyStimulus(1, 19'h00021, 1, 19'h11111, 1, 0);
    tick();
    tick();
    applyStimulus(0, 19'h00021, 0, '0, 0, 0);
    checkOutput("errIgnRdEn",  32'(mem_rd_en),   0);
    checkOutput("errIgnErr",   32'(fetch_error), 1);
    checkOutput("errIgnIrVal", 32'(ir_valid),    0);
    applyStimulus(0, 19'h00021, 0, '0, 0, 1);
    tick();
    applyStimulus(0, 19'h00021, 0, '0, 0, 0);
    checkOutput("flushErr",  32'(fetch_error), 0);
    checkOutput("flushBusy", 32'(fetch_busy),  0);

    $display("[TB] late boundary response");
    applyStimulus(1, 19'h00021, 0, '0, 0, 0);
    tick();
    applyStimulus(0, 19'h00021, 0, '0, 0, 0);
    tick();
    repeat (TO - 1) tick();
    applyStimulus(0, 19'h00021, 1, 19'h31415, 0, 0);
    expQ.push_back(19'h31415);
    tick();
    applyStimulus(0, 19'h00021, 0, '0, 1, 0);
    checkOutput("lateIrVal", 32'(ir_valid),    1);
    checkOutput("lateErr",   32'(fetch_error), 0);
    checkOutput("lateInc",   32'(inc_pc_req),  1);
    tick();
    applyStimulus(0, 19'h00021, 0, '0, 0, 0);

    $display("[TB] flush during wait");
    applyStimulus(1, 19'h00022, 0, '0, 0, 0);
    tick();
    applyStimulus(0, 19'h00022, 0, '0, 0, 0);
    tick();
    applyStimulus(0, 19'h00022, 0, '0, 0, 1);
    tick();
    applyStimulus(0, 19'h00022, 1, 19'h7FFFF, 0, 0);
    tick();
    applyStimulus(0, 19'h00022, 0, '0, 0, 0);
    checkOutput("flushIrVal", 32'(ir_valid),   0);
    checkOutput("flushInc",   32'(inc_pc_req), 0);
    checkOutput("flushIdle",  32'(fetch_busy), 0);
    checkOutput("flushIrKeep", 32'(ir_out),    32'h31415);

    $display("[TB] reset during hold");
    applyStimulus(1, 19'h00030, 0, '0, 0, 0);
    tick();
    applyStimulus(0, 19'h00030, 0, '0, 0, 0);
    tick();
    applyStimulus(0, 19'h00030, 1, 19'h12345, 0, 0);
    tick();
    checkOutput("preRstIrVal", 32'(ir_valid), 1);
    RESET = 1'b1;
    applyStimulus(0, 19'h00030, 1, 19'h54321, 0, 0);
    tick();
    checkAllZero("midRst");
    RESET = 1'b0;
    applyStimulus(1, 19'h00000, 0, '0, 0, 0);
    tick();
    checkOutput("postRstRdEn", 32'(mem_rd_en), 1);
    checkOutput("postRstAddr", 32'(mem_addr),  0);

    $display("[TB] randomised back-to-back stream");
    addr = 19'h00000;
    for (int i = 0; i < 8; i++) begin
      checkOutput("streamRdEn", 32'(mem_rd_en), 1);
      checkOutput("streamAddr", 32'(mem_addr),  32'(addr));
      applyStimulus(0, addr, 0, '0, 0, 0);
      tick();
      lat = $urandom_range(0, TO - 1);
      repeat (lat) tick();
      data = DW'($urandom);
      applyStimulus(0, addr, 1, data, 0, 0);
      expQ.push_back(data);
      tick();
      checkOutput("streamIrVal", 32'(ir_valid),   1);
      checkOutput("streamInc",   32'(inc_pc_req), 1);
      checkOutput("streamErr",   32'(fetch_error), 0);
      addr = addr + AW'(1);
      applyStimulus(1, addr, 0, '0, 1, 0);
      tick();
    end
    applyStimulus(0, addr, 0, '0, 0, 1);
    tick();
    applyStimulus(0, addr, 0, '0, 0, 0);
    tick();

    checkOutput("sbDrained", 32'(expQ.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
